matrix_loader: RTL

Upstream feeder for the matrix multiply unit. It takes a byte stream through a valid/ready handshake: dimension m, then dimension n, then m*n elements in row-major order. It packs them into the fixed 5x5 by 8-bit packed matrix format with dimensions the multiplier consumes. Two instances produce matrixA/a_m/a_n and matrixB/b_m/b_n.

---
 rtl/matrix_pkg.sv | 25 ++
 rtl/matrix_loader.sv | 101 ++++++++++
 2 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix datapath: the loaders, the multiply
// unit and the result serializer all agree on these sizes and layouts.
package matrix_pkg;

  localparam int MAX_DIM  = 5;
  localparam int ELEM_W   = 8;
  localparam int DIM_W    = 3;
  localparam int MAT_BITS = MAX_DIM * MAX_DIM * ELEM_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_M,
    ST_GET_N,
    ST_GET_ELEM,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  // Row-major slot number of element (i,j) inside the packed matrix.
  function automatic int slot_index(input logic [DIM_W-1:0] i,
                                    input logic [DIM_W-1:0] j);
    return (int'(i) * MAX_DIM) + int'(j);
  endfunction

endpackage

// File: rtl/matrix_loader.sv
// Byte-stream loader: takes m, n and then m*n row-major elements over a
// valid/ready handshake and packs them into the fixed 5x5 matrix format.
module matrix_loader
  import matrix_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  input  logic [ELEM_W-1:0]   in_data,
  output logic                in_ready,
  output logic                busy,
  output logic [DIM_W-1:0]    mat_m,
  output logic [DIM_W-1:0]    mat_n,
  output logic [MAT_BITS-1:0] matrix,
  output logic                done,
  output logic                dim_error
);

  localparam logic [DIM_W-1:0]  DIM_ONE  = DIM_W'(1);
  localparam logic [ELEM_W-1:0] DIM_MAX8 = ELEM_W'(MAX_DIM);

  loader_state_t    state;
  logic [DIM_W-1:0] row;
  logic [DIM_W-1:0] col;
  logic             dim_legal;

  // A dimension byte is legal only if the whole byte lies in 1..MAX_DIM.
  always_comb begin
    dim_legal = (in_data != '0) && (in_data <= DIM_MAX8);
  end

  // Handshake and status flags come straight from the state register, so
  // in_valid never reaches in_ready combinationally.
  always_comb begin
    in_ready  = (state == ST_GET_M) || (state == ST_GET_N) || (state == ST_GET_ELEM);
    busy      = in_ready;
    done      = (state == ST_DONE);
    dim_error = (state == ST_ERR);
  end

  // Load FSM with row/col counters; start overrides everything, including a byte offered in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      mat_m  <= '0;
      mat_n  <= '0;
      matrix <= '0;
      row    <= '0;
      col    <= '0;
    end else if (start) begin
      state  <= ST_GET_M;
      mat_m  <= '0;
      mat_n  <= '0;
      matrix <= '0;
      row    <= '0;
      col    <= '0;
    end else begin
      case (state)
        ST_GET_M: begin
          if (in_valid) begin
            if (dim_legal) begin
              mat_m <= in_data[DIM_W-1:0];
              state <= ST_GET_N;
            end else begin
              state <= ST_ERR;
            end
          end
        end
        ST_GET_N: begin
          if (in_valid) begin
            if (dim_legal) begin
              mat_n <= in_data[DIM_W-1:0];
              state <= ST_GET_ELEM;
            end else begin
              state <= ST_ERR;
            end
          end
        end
        ST_GET_ELEM: begin
          if (in_valid) begin
            matrix[slot_index(row, col)*ELEM_W +: ELEM_W] <= in_data;
            if (col == mat_n - DIM_ONE) begin
              col <= '0;
              row <= row + DIM_ONE;
              if (row == mat_m - DIM_ONE) begin
                state <= ST_DONE;
              end
            end else begin
              col <= col + DIM_ONE;
            end
          end
        end
        ST_DONE: state <= ST_DONE;
        ST_ERR:  state <= ST_ERR;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
